// File: rtl/clk_sched_pkg.sv
// Shared types and elaboration-time helpers for the clock-enable scheduler.
//   state_t            : configuration FSM states
//   calc_ch_w()        : channel-index width, never below one bit
//   calc_default_div() : reset divisor giving DEFAULT_OUT_HZ on clk_o
package clk_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    APPLY     = 2'd1,
    WAIT_EDGE = 2'd2
  } state_t;

  function automatic int calc_ch_w(input int num_ch);
    int w;
    w = $clog2(num_ch);
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

  // clk_o toggles once per tick, so one output period spans two ticks.
  function automatic int calc_default_div(input int src_hz, input int out_hz);
    return src_hz / (32'sd2 * out_hz);
  endfunction

endpackage

// File: rtl/clk_sched_channel.sv
// One programmable divider channel.
//   clk_in/rst_n : source clock, async active-low reset
//   apply        : write cfg_en/cfg_div, restart counter and clk_div at 0
//   load         : take cfg_div at the next wrap or restart (glitch-free retune)
//   restart      : phase-align an enabled channel (counter 0, clk_div 0)
//   tick         : one-cycle enable while counter == D-1 (D = 0 acts as 1)
//   clk_div      : toggles on the edge after each tick
//   en           : current enable state, used by the controller
module clk_sched_channel
  import clk_sched_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int RST_DIV = 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             apply,
  input  logic             load,
  input  logic             restart,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick,
  output logic             clk_div,
  output logic             en
);

  localparam logic [DIV_W-1:0] ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic             en_r, clk_r, tick_r;
  logic [DIV_W-1:0] div_r, cnt_r;
  logic             en_s, clk_s, tick_s;
  logic [DIV_W-1:0] div_s, cnt_s;

  function automatic logic [DIV_W-1:0] last_count(input logic [DIV_W-1:0] d);
    return (d == ZERO) ? ZERO : (d - ONE);
  endfunction

  // Next-state of the channel; tick is precomputed so it leaves a flop.
  always_comb begin
    en_s  = en_r;
    div_s = div_r;
    cnt_s = cnt_r;
    clk_s = clk_r;
    if (apply) begin
      en_s  = cfg_en;
      div_s = cfg_div;
      cnt_s = ZERO;
      clk_s = 1'b0;
    end else if (!en_r) begin
      cnt_s = ZERO;
      clk_s = 1'b0;
    end else if (restart) begin
      // Restart wins over a wrap in the same cycle.
      cnt_s = ZERO;
      clk_s = 1'b0;
      div_s = load ? cfg_div : div_r;
    end else if (tick_r) begin
      // A retune lands exactly on the wrap, so no half-period is cut short.
      cnt_s = ZERO;
      clk_s = ~clk_r;
      div_s = load ? cfg_div : div_r;
    end else begin
      cnt_s = cnt_r + ONE;
    end
    tick_s = en_s && (cnt_s == last_count(div_s));
  end

  // Channel state registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      en_r   <= 1'b0;
      div_r  <= DIV_W'(RST_DIV);
      cnt_r  <= ZERO;
      clk_r  <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      en_r   <= en_s;
      div_r  <= div_s;
      cnt_r  <= cnt_s;
      clk_r  <= clk_s;
      tick_r <= tick_s;
    end
  end

  assign tick    = tick_r;
  assign clk_div = clk_r;
  assign en      = en_r;

endmodule

// File: rtl/clk_sched_ctrl.sv
// Multi-channel clock-enable scheduler with a valid/ready config port.
//   clk_in, rst_n      : source clock, async active-low reset
//   cfg_valid/ready    : request handshake (ready while FSM is IDLE)
//   cfg_ch/div/en      : target channel, divisor, enable
//   cfg_err            : one-cycle pulse for an out-of-range channel
//   sync_start         : phase-align all enabled channels
//   tick_o, clk_o      : per-channel enable pulse and divided clock
//   busy               : an update is pending (APPLY or WAIT_EDGE)
module clk_sched_ctrl
  import clk_sched_pkg::*;
#(
  parameter  int SRC_FREQ_HZ    = 12_000_000,
  parameter  int DEFAULT_OUT_HZ = 1_000,
  parameter  int NUM_CH         = 4,
  parameter  int DIV_W          = 16,
  localparam int CH_W           = calc_ch_w(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_en,
  output logic              cfg_err,
  input  logic              sync_start,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] clk_o,
  output logic              busy
);

  localparam int              DEFAULT_DIV = calc_default_div(SRC_FREQ_HZ, DEFAULT_OUT_HZ);
  localparam logic [CH_W:0]   NUM_CH_V    = (CH_W+1)'(NUM_CH);

  state_t             state_r, state_s;
  logic [CH_W-1:0]    cap_ch_r, cap_ch_s;
  logic [DIV_W-1:0]   cap_div_r, cap_div_s;
  logic               cap_en_r, cap_en_s;
  logic               err_r, err_s;
  logic               ready_r, busy_r;
  logic               accept_s, in_range_s, tgt_en_s, tgt_tick_s;
  logic [NUM_CH-1:0]  ch_en_s, apply_s, load_s;

  assign accept_s   = cfg_valid && ready_r;
  assign in_range_s = ({1'b0, cfg_ch} < NUM_CH_V);

  // Enable of the requested channel and tick of the captured target.
  always_comb begin
    tgt_en_s   = 1'b0;
    tgt_tick_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      tgt_en_s   = (cfg_ch   == CH_W'(i)) ? ch_en_s[i] : tgt_en_s;
      tgt_tick_s = (cap_ch_r == CH_W'(i)) ? tick_o[i]  : tgt_tick_s;
    end
  end

  // Configuration FSM next-state and request capture.
  always_comb begin
    state_s   = state_r;
    cap_ch_s  = cap_ch_r;
    cap_div_s = cap_div_r;
    cap_en_s  = cap_en_r;
    err_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          cap_ch_s  = cfg_ch;
          cap_div_s = cfg_div;
          cap_en_s  = cfg_en;
          err_s     = !in_range_s;
          if (!in_range_s) begin
            state_s = IDLE;
          end else if (tgt_en_s && cfg_en) begin
            // Running channel: keep the old divisor until its own tick.
            state_s = WAIT_EDGE;
          end else begin
            state_s = APPLY;
          end
        end else begin
          state_s = IDLE;
        end
      end
      APPLY: begin
        state_s = IDLE;
      end
      WAIT_EDGE: begin
        if (sync_start || tgt_tick_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_EDGE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, captured request and registered status outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cap_ch_r  <= {CH_W{1'b0}};
      cap_div_r <= {DIV_W{1'b0}};
      cap_en_r  <= 1'b0;
      err_r     <= 1'b0;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cap_ch_r  <= cap_ch_s;
      cap_div_r <= cap_div_s;
      cap_en_r  <= cap_en_s;
      err_r     <= err_s;
      ready_r   <= (state_s == IDLE);
      busy_r    <= (state_s != IDLE);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign apply_s[i] = (state_r == APPLY)     && (cap_ch_r == CH_W'(i));
    assign load_s[i]  = (state_r == WAIT_EDGE) && (cap_ch_r == CH_W'(i));

    clk_sched_channel #(
      .DIV_W   (DIV_W),
      .RST_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .apply   (apply_s[i]),
      .load    (load_s[i]),
      .restart (sync_start),
      .cfg_en  (cap_en_r),
      .cfg_div (cap_div_r),
      .tick    (tick_o[i]),
      .clk_div (clk_o[i]),
      .en      (ch_en_s[i])
    );
  end

  assign cfg_ready = ready_r;
  assign cfg_err   = err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_clk_sched_ctrl.sv
// Scoreboard bench for clk_sched_ctrl (3 channels so an out-of-range index
// exists). Stimulus pushes expected tick/err cycle numbers into queues; a
// negedge monitor pops and compares whenever the DUT pulses an output.
module tb_clk_sched_ctrl;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 16;

  logic              clk_in = 1'b0;
  logic              rst_n  = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [1:0]        cfg_ch = 2'd0;
  logic [DIV_W-1:0]  cfg_div = 16'd0;
  logic              cfg_en = 1'b0;
  logic              cfg_err;
  logic              sync_start = 1'b0;
  logic [NUM_CH-1:0] tick_o;
  logic [NUM_CH-1:0] clk_o;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int q0[$];
  int q1[$];
  int q2[$];
  int qerr[$];

  clk_sched_ctrl #(
    .SRC_FREQ_HZ    (12_000_000),
    .DEFAULT_OUT_HZ (1_000),
    .NUM_CH         (NUM_CH),
    .DIV_W          (DIV_W)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_en     (cfg_en),
    .cfg_err    (cfg_err),
    .sync_start (sync_start),
    .tick_o     (tick_o),
    .clk_o      (clk_o),
    .busy       (busy)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 1000) begin
      step();
      guard++;
    end
    check("timeline", cyc, n);
  endtask

  task automatic push_tick(input int ch, input int c);
    case (ch)
      0: q0.push_back(c);
      1: q1.push_back(c);
      default: q2.push_back(c);
    endcase
  endtask

  task automatic send_cfg(input int ch, input int div, input logic en, output int t);
    logic rdy;
    int   n;
    cfg_ch    = 2'(ch);
    cfg_div   = 16'(div);
    cfg_en    = en;
    cfg_valid = 1'b1;
    n = 0;
    do begin
      rdy = cfg_ready;
      step();
      n++;
    end while (!rdy && n < 50);
    if (!rdy) check("cfg_accept_timeout", 0, 1);
    t = cyc;
    cfg_valid = 1'b0;
  endtask

  task automatic mon_tick(input int ch);
    int e;
    int have;
    have = 0;
    e = -1;
    case (ch)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
    endcase
    if (have == 0) check($sformatf("tick%0d_unexpected", ch), cyc, -1);
    else           check($sformatf("tick%0d_cycle", ch), cyc, e);
  endtask

  // Scoreboard monitor: compares every output pulse against the queues.
  always @(negedge clk_in) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (tick_o[i] === 1'b1) mon_tick(i);
    end
    if (cfg_err === 1'b1) begin
      if (qerr.size() > 0) check("cfg_err_cycle", cyc, qerr.pop_front());
      else                 check("cfg_err_unexpected", cyc, -1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, a, x, e, p, q, s, d0, d1, r, y, u, w;

    repeat (3) @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    step();
    step();
    check("rst_tick_o", int'(tick_o), 0);
    check("rst_clk_o", int'(clk_o), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_cfg_err", int'(cfg_err), 0);

    // Enable ch0 with D=5.
    send_cfg(0, 5, 1'b1, t);
    check("en_busy_hi", int'(busy), 1);
    push_tick(0, t + 5);
    push_tick(0, t + 10);
    push_tick(0, t + 15);
    step();
    check("en_busy_lo", int'(busy), 0);
    check("en_ready", int'(cfg_ready), 1);
    wait_cyc(t + 5);
    check("d5_clk_before", int'(clk_o[0]), 0);
    wait_cyc(t + 6);
    check("d5_clk_rise", int'(clk_o[0]), 1);
    wait_cyc(t + 11);
    check("d5_clk_fall", int'(clk_o[0]), 0);

    // Retune ch0 to D=3 mid-period; takes effect at the t+15 tick.
    wait_cyc(t + 12);
    send_cfg(0, 3, 1'b1, a);
    check("retune_accept", a, t + 13);
    check("retune_busy0", int'(busy), 1);
    push_tick(0, t + 18);
    push_tick(0, t + 21);
    push_tick(0, t + 24);
    wait_cyc(t + 15);
    check("retune_busy_hold", int'(busy), 1);
    check("retune_clk_low", int'(clk_o[0]), 0);
    wait_cyc(t + 16);
    check("retune_busy_done", int'(busy), 0);
    check("retune_clk_rise", int'(clk_o[0]), 1);
    wait_cyc(t + 18);
    check("retune_clk_hi", int'(clk_o[0]), 1);
    wait_cyc(t + 19);
    check("retune_clk_fall", int'(clk_o[0]), 0);

    // Disable ch0.
    wait_cyc(t + 24);
    send_cfg(0, 5, 1'b0, x);
    check("dis_accept", x, t + 25);
    wait_cyc(x + 2);
    check("dis_tick", int'(tick_o[0]), 0);
    check("dis_clk", int'(clk_o[0]), 0);

    // Out-of-range channel index.
    send_cfg(3, 7, 1'b1, e);
    qerr.push_back(e);
    check("err_ready", int'(cfg_ready), 1);
    check("err_busy", int'(busy), 0);
    step();
    check("err_ready_after", int'(cfg_ready), 1);
    check("err_pulse_end", int'(cfg_err), 0);

    // ch0 D=4, ch1 D=6, then sync_start.
    send_cfg(0, 4, 1'b1, p);
    push_tick(0, p + 4);
    push_tick(0, p + 8);
    send_cfg(1, 6, 1'b1, q);
    check("sync_ch1_accept", q, p + 2);
    push_tick(1, q + 6);
    wait_cyc(q + 8);
    check("sync_pre_clk1", int'(clk_o[1]), 1);
    sync_start = 1'b1;
    step();
    sync_start = 1'b0;
    s = cyc;
    check("sync_clk_zero", int'(clk_o[1:0]), 0);
    push_tick(0, s + 3);
    push_tick(0, s + 7);
    push_tick(0, s + 11);
    push_tick(1, s + 5);
    push_tick(1, s + 11);
    wait_cyc(s + 11);
    send_cfg(0, 4, 1'b0, d0);
    check("sync_dis0", d0, s + 12);
    send_cfg(1, 6, 1'b0, d1);
    check("sync_dis1", d1, s + 14);

    // D=0 on ch2 behaves as D=1.
    send_cfg(2, 0, 1'b1, r);
    for (int k = 1; k <= 7; k++) push_tick(2, r + k);
    wait_cyc(r + 1);
    check("d0_clk_a", int'(clk_o[2]), 0);
    wait_cyc(r + 2);
    check("d0_clk_b", int'(clk_o[2]), 1);
    wait_cyc(r + 3);
    check("d0_clk_c", int'(clk_o[2]), 0);
    wait_cyc(r + 6);
    send_cfg(2, 0, 1'b0, y);
    check("d0_dis_accept", y, r + 7);
    wait_cyc(y + 2);
    check("d0_dis_tick", int'(tick_o), 0);

    // Reset while a retune is pending.
    send_cfg(0, 6, 1'b1, u);
    push_tick(0, u + 6);
    wait_cyc(u + 7);
    send_cfg(0, 2, 1'b1, w);
    check("rw_accept", w, u + 8);
    wait_cyc(u + 10);
    check("rw_busy", int'(busy), 1);
    check("rw_clk_hi", int'(clk_o[0]), 1);
    @(negedge clk_in);
    rst_n = 1'b0;
    #1;
    check("rw_tick", int'(tick_o), 0);
    check("rw_clk", int'(clk_o), 0);
    check("rw_busy_lo", int'(busy), 0);
    check("rw_err", int'(cfg_err), 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    step();
    check("rw_ready", int'(cfg_ready), 1);
    repeat (20) step();
    check("rw_clk_after", int'(clk_o), 0);
    check("rw_busy_after", int'(busy), 0);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);
    check("qerr_drained", qerr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
